// File: rtl/tlb_ctrl.sv
// tlb_ctrl: CP0 TLB instruction sequencer (TLBR, TLBWI, TLBWR, TLBP) for a
// 16-entry TLB. It drives the write port and a combinational read port, scans
// entries one per cycle for a probe, and keeps the Random register.
module tlb_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    input  logic [31:0] entryhi_i,
    input  logic [31:0] entrylo0_i,
    input  logic [31:0] entrylo1_i,
    input  logic [31:0] index_i,
    input  logic [3:0]  wired_i,
    output logic        tlb_we,
    output logic [3:0]  tlb_index,
    output logic [62:0] tlb_data,
    output logic [3:0]  tlb_rd_index,
    input  logic [62:0] tlb_rd_data,
    output logic        index_we,
    output logic [31:0] index_o,
    output logic        entry_we,
    output logic [31:0] entryhi_o,
    output logic [31:0] entrylo0_o,
    output logic [31:0] entrylo1_o,
    output logic [3:0]  random_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_PROBE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;

    state_t      state_q;
    logic        done_q, tlb_we_q, index_we_q, entry_we_q;
    logic [3:0]  tlb_index_q, rd_idx_q, random_q, random_d;
    logic [62:0] tlb_data_q;
    logic [18:0] vpn2_q;
    logic [31:0] index_o_q, entryhi_q, entrylo0_q, entrylo1_q;
    logic [62:0] wr_data_d;
    logic        probe_hit_d;
    logic        unused_bits;

    // Entry image built from the CP0 registers: {VPN2, PFN1, D1, V1, PFN0, D0, V0}
    assign wr_data_d = {entryhi_i[31:13],
                        entrylo1_i[25:6], entrylo1_i[2], entrylo1_i[1],
                        entrylo0_i[25:6], entrylo0_i[2], entrylo0_i[1]};

    assign probe_hit_d = (tlb_rd_data[62:44] == vpn2_q);

    // Random counts down every cycle and wraps to 15 once it reaches Wired
    assign random_d = (random_q <= wired_i) ? 4'd15 : random_q - 4'd1;

    // Register fields that the TLB format does not carry
    assign unused_bits = ^{entryhi_i[12:0], entrylo0_i[31:26], entrylo0_i[5:3],
                           entrylo0_i[0], entrylo1_i[31:26], entrylo1_i[5:3],
                           entrylo1_i[0], index_i[31:4]};

    // Random register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            random_q <= 4'd15;
        end else begin
            random_q <= random_d;
        end
    end

    // Sequencer FSM with registered strobes and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            tlb_we_q    <= 1'b0;
            index_we_q  <= 1'b0;
            entry_we_q  <= 1'b0;
            tlb_index_q <= 4'd0;
            tlb_data_q  <= 63'd0;
            rd_idx_q    <= 4'd0;
            vpn2_q      <= 19'd0;
            index_o_q   <= 32'd0;
            entryhi_q   <= 32'd0;
            entrylo0_q  <= 32'd0;
            entrylo1_q  <= 32'd0;
        end else begin
            done_q     <= 1'b0;
            tlb_we_q   <= 1'b0;
            index_we_q <= 1'b0;
            entry_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        vpn2_q <= entryhi_i[31:13];
                        case (op)
                            OP_TLBR: begin
                                rd_idx_q <= index_i[3:0];
                                state_q  <= S_READ;
                            end
                            OP_TLBWI, OP_TLBWR: begin
                                // Strobe is raised on entry so it is seen during WRITE
                                tlb_we_q    <= 1'b1;
                                done_q      <= 1'b1;
                                tlb_index_q <= (op == OP_TLBWI) ? index_i[3:0] : random_q;
                                tlb_data_q  <= wr_data_d;
                                state_q     <= S_WRITE;
                            end
                            default: begin
                                rd_idx_q <= 4'd0;
                                state_q  <= S_PROBE;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    entryhi_q  <= {tlb_rd_data[62:44], 13'd0};
                    entrylo1_q <= {6'd0, tlb_rd_data[43:24], 3'd0, tlb_rd_data[23],
                                   tlb_rd_data[22], 1'b0};
                    entrylo0_q <= {6'd0, tlb_rd_data[21:2], 3'd0, tlb_rd_data[1],
                                   tlb_rd_data[0], 1'b0};
                    entry_we_q <= 1'b1;
                    done_q     <= 1'b1;
                    rd_idx_q   <= 4'd0;
                    state_q    <= S_FIN;
                end
                S_PROBE: begin
                    if (probe_hit_d || rd_idx_q == 4'd15) begin
                        index_o_q  <= probe_hit_d ? {28'd0, rd_idx_q} : 32'h8000_0000;
                        index_we_q <= 1'b1;
                        done_q     <= 1'b1;
                        rd_idx_q   <= 4'd0;
                        state_q    <= S_FIN;
                    end else begin
                        rd_idx_q <= rd_idx_q + 4'd1;
                    end
                end
                S_WRITE, S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign tlb_we       = tlb_we_q;
    assign tlb_index    = tlb_index_q;
    assign tlb_data     = tlb_data_q;
    assign tlb_rd_index = rd_idx_q;
    assign index_we     = index_we_q;
    assign index_o      = index_o_q;
    assign entry_we     = entry_we_q;
    assign entryhi_o    = entryhi_q;
    assign entrylo0_o   = entrylo0_q;
    assign entrylo1_o   = entrylo1_q;
    assign random_o     = random_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed plus randomized checks of tlb_ctrl against a
// behavioural TLB array and timing model held in the bench.
module tb_tlb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        busy, done;
    logic [31:0] entryhi_i, entrylo0_i, entrylo1_i, index_i;
    logic [3:0]  wired_i;
    logic        tlb_we;
    logic [3:0]  tlb_index;
    logic [62:0] tlb_data;
    logic [3:0]  tlb_rd_index;
    logic [62:0] tlb_rd_data;
    logic        index_we;
    logic [31:0] index_o;
    logic        entry_we;
    logic [31:0] entryhi_o, entrylo0_o, entrylo1_o;
    logic [3:0]  random_o;

    logic [62:0] mem [16];
    logic [3:0]  rnd_m;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    tlb_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .busy(busy), .done(done),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
        .index_i(index_i), .wired_i(wired_i),
        .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_data(tlb_data),
        .tlb_rd_index(tlb_rd_index), .tlb_rd_data(tlb_rd_data),
        .index_we(index_we), .index_o(index_o), .entry_we(entry_we),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
        .random_o(random_o)
    );

    // TLB storage seen by the read port
    assign tlb_rd_data = mem[tlb_rd_index];

    // Random register rule: count down, wrap to 15 at or below Wired
    always @(posedge clk) begin
        if (!rst) rnd_m <= 4'd15;
        else      rnd_m <= (rnd_m <= wired_i) ? 4'd15 : rnd_m - 4'd1;
    end

    function automatic logic [62:0] pack(input logic [31:0] hi, lo0, lo1);
        return {hi[31:13], lo1[25:6], lo1[2], lo1[1], lo0[25:6], lo0[2], lo0[1]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at the current negedge and check its completion
    task automatic run_op(input logic [1:0] o, input logic [31:0] hi, lo0, lo1, idx,
                          input bit noise);
        logic [3:0]  exp_idx;
        logic [62:0] exp_data;
        logic [62:0] e;
        int          exp_lat, lat, k;
        entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1; index_i = idx;
        op = o; op_valid = 1'b1;
        exp_idx  = (o == 2'b01) ? idx[3:0] : rnd_m;
        exp_data = pack(hi, lo0, lo1);
        e        = mem[idx[3:0]];
        k = -1;
        for (int i = 0; i < 16; i++)
            if (k < 0 && mem[i][62:44] == hi[31:13]) k = i;
        case (o)
            2'b00:   exp_lat = 2;
            2'b11:   exp_lat = (k < 0) ? 17 : k + 2;
            default: exp_lat = 1;
        endcase
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            op_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            op = 2'($urandom_range(0, 3));
        end
        op_valid = 1'b0;
        chk($sformatf("latency_op%0d", o), 64'(lat), 64'(exp_lat));
        if (done === 1'b1) begin
            chk("busy_at_done", 64'(busy), 64'd1);
            case (o)
                2'b00: begin
                    chk("read_strobes", {61'd0, tlb_we, index_we, entry_we}, 64'd1);
                    chk("read_hi", 64'(entryhi_o), {32'd0, e[62:44], 13'd0});
                    chk("read_lo1", 64'(entrylo1_o),
                        {32'd0, 6'd0, e[43:24], 3'd0, e[23], e[22], 1'b0});
                    chk("read_lo0", 64'(entrylo0_o),
                        {32'd0, 6'd0, e[21:2], 3'd0, e[1], e[0], 1'b0});
                end
                2'b11: begin
                    chk("probe_strobes", {61'd0, tlb_we, index_we, entry_we}, 64'd2);
                    chk("probe_index", 64'(index_o),
                        (k < 0) ? 64'h8000_0000 : 64'(k));
                end
                default: begin
                    chk("write_strobes", {61'd0, tlb_we, index_we, entry_we}, 64'd4);
                    chk("write_index", 64'(tlb_index), 64'(exp_idx));
                    chk("write_data", 64'(tlb_data), 64'(exp_data));
                    mem[exp_idx] = exp_data;
                end
            endcase
        end
        @(negedge clk);
        chk("after_done", {60'd0, done, tlb_we, index_we, entry_we}, 64'd0);
        chk("after_busy", 64'(busy), 64'd0);
        chk("random_track", 64'(random_o), 64'(rnd_m));
        $display("op=%0d hi=%h idx=%0d latency=%0d expected=%0d", o, hi, idx[3:0], lat, exp_lat);
    endtask

    initial begin
        int        cnt;
        bit        seen;
        logic [31:0] hi;
        logic [1:0]  o;
        rst = 1'b0; op_valid = 1'b0; op = 2'b00; wired_i = 4'd3;
        entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0; index_i = '0;
        for (int i = 0; i < 16; i++)
            mem[i] = {19'h40000 | 19'(i), 44'($urandom) ^ {12'd0, 32'($urandom)}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strobes", {59'd0, busy, done, tlb_we, index_we, entry_we}, 64'd0);
        chk("rst_tlb_index", 64'(tlb_index), 64'd0);
        chk("rst_rd_index", 64'(tlb_rd_index), 64'd0);
        chk("rst_tlb_data", 64'(tlb_data), 64'd0);
        chk("rst_index_o", 64'(index_o), 64'd0);
        chk("rst_entry_o", {32'd0, entryhi_o | entrylo0_o | entrylo1_o}, 64'd0);
        chk("rst_random", 64'(random_o), 64'd15);

        // Random sequence with Wired=3: 15,14,...,3,15
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("random_seq%0d", i), 64'(random_o),
                (i < 13) ? 64'(15 - i) : 64'd15);
            $display("random step %0d value=%0d", i, random_o);
            @(negedge clk);
        end

        // TLBWI to index 5
        run_op(2'b01, 32'h0040_2000, 32'h0000_0046, 32'h0000_0086, 32'd5, 1'b0);
        chk("wi_literal_data", 64'(tlb_data),
            64'({19'h00201, 20'h2, 1'b1, 1'b1, 20'h1, 1'b1, 1'b1}));
        chk("wi_literal_index", 64'(tlb_index), 64'd5);

        // TLBR from index 5
        run_op(2'b00, 32'd0, 32'd0, 32'd0, 32'd5, 1'b0);
        chk("r_literal_hi", 64'(entryhi_o), 64'h0040_2000);
        chk("r_literal_lo0", 64'(entrylo0_o), 64'h0000_0046);
        chk("r_literal_lo1", 64'(entrylo1_o), 64'h0000_0086);

        // TLBP hit at 9 (also present at 12)
        mem[9][62:44]  = 19'h12345;
        mem[12][62:44] = 19'h12345;
        run_op(2'b11, {19'h12345, 13'h0}, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("p_literal_hit", 64'(index_o), 64'd9);

        // TLBP miss with ignored op_valid pulses during the scan
        run_op(2'b11, {19'h7ffff, 13'h0}, 32'd0, 32'd0, 32'd0, 1'b1);
        chk("p_literal_miss", 64'(index_o), 64'h8000_0000);

        // TLBWR accepted while Random=7
        cnt = 0;
        while (rnd_m != 4'd7 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("wr_random_is7", 64'(random_o), 64'd7);
        run_op(2'b10, 32'h1234_6000, 32'h0000_1242, 32'h0000_2084, 32'd0, 1'b0);
        chk("wr_literal_index", 64'(tlb_index), 64'd7);

        // Reset during a probe scan
        entryhi_i = {19'h7ffff, 13'h0}; op = 2'b11; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_strobes", {60'd0, done, tlb_we, index_we, entry_we}, 64'd0);
        chk("midrst_random", 64'(random_o), 64'd15);
        chk("midrst_rd_index", 64'(tlb_rd_index), 64'd0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || index_we || busy) seen = 1'b1;
        end
        chk("midrst_no_pulse", 64'(seen), 64'd0);

        // Randomized instruction mix
        for (int t = 0; t < 40; t++) begin
            wired_i = 4'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            hi = $urandom;
            if (o == 2'b11 && $urandom_range(0, 1) == 1)
                hi[31:13] = mem[$urandom_range(0, 15)][62:44];
            run_op(o, hi, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameters: none; entry count fixed at 16, entry width 63 bits.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets).
- op_valid  in  1  CP0 TLB instruction request.
- op  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- entryhi_i, entrylo0_i, entrylo1_i, index_i  in  32 each  current CP0 register values.
- wired_i  in  4  CP0 Wired.
- tlb_we  out  1  TLB entry write strobe.
- tlb_index  out  4  write index.
- tlb_data  out  63  write data.
- tlb_rd_index  out  4  TLB read index.
- tlb_rd_data  in  63  TLB entry at tlb_rd_index, combinational.
- index_we  out  1  write index_o into CP0 Index.
- index_o  out  32  probe result.
- entry_we  out  1  write EntryHi/EntryLo0/EntryLo1.
- entryhi_o, entrylo0_o, entrylo1_o  out  32 each  TLBR result.
- random_o  out  4  CP0 Random.

Function
REQ-003 SHALL pack entries as {VPN2[62:44], PFN1[43:24], D1[23], V1[22], PFN0[21:2], D0[1], V0[0]}.
REQ-004 SHALL form write data as {entryhi_i[31:13], entrylo1_i[25:6], entrylo1_i[2], entrylo1_i[1], entrylo0_i[25:6], entrylo0_i[2], entrylo0_i[1]}.
REQ-005 SHALL implement states IDLE, WRITE, READ, PROBE, FIN; busy=1 in every state except IDLE.
REQ-006 SHALL accept op_valid only in IDLE; op_valid in any other state is ignored.
REQ-007 At acceptance SHALL capture op, write data, index_i[3:0], VPN2, and random_o.
REQ-008 TLBWI/TLBWR: WRITE lasts one cycle.
- tlb_we=1, done=1, tlb_index = captured index_i[3:0] (TLBWI) or captured random_o (TLBWR).
- Then IDLE.
REQ-009 TLBR:
- READ drives tlb_rd_index = captured index for one cycle and registers tlb_rd_data.
- FIN then pulses entry_we=1 and done=1.
- Latency: done 2 cycles after acceptance.
REQ-010 TLBR outputs:
- entryhi_o = {VPN2,13'b0}.
- entrylo1_o = {6'b0,PFN1,3'b0,D1,V1,1'b0}.
- entrylo0_o = {6'b0,PFN0,3'b0,D0,V0,1'b0}.
REQ-011 TLBP: PROBE scans idx 0..15, one per cycle, via tlb_rd_index=idx; match means tlb_rd_data[62:44]==captured VPN2.
REQ-012 TLBP completion:
- First (lowest) match k: FIN next cycle, index_o={28'b0,k}, index_we=1, done=1; done k+2 cycles after acceptance.
- No match after idx 15: index_o=32'h8000_0000, index_we=1, done=1; done 17 cycles after acceptance.
REQ-013 tlb_we, index_we, entry_we, done SHALL be registered single-cycle pulses, otherwise 0; tlb_index/tlb_data hold last value.
REQ-014 random_o SHALL decrement by 1 every cycle; when random_o <= wired_i the next value SHALL be 15.
- wired_i=15 holds random_o at 15.
- TLBWR uses the value captured at acceptance, not the later counter value.
REQ-015 tlb_rd_index SHALL be 0 in IDLE, WRITE, and FIN.
REQ-016 Acceptance in the same cycle as a done pulse is impossible, since done occurs outside IDLE; back-to-back ops are spaced by at least one IDLE cycle.

Reset
REQ-017 With rst==0 at a clock edge the block SHALL go to IDLE, with:
- busy, done, tlb_we, index_we, entry_we = 0.
- tlb_index, tlb_rd_index = 0.
- tlb_data, index_o, entryhi_o, entrylo0_o, entrylo1_o = 0.
- random_o = 15.
REQ-018 Reset mid-operation SHALL abort with no tlb_we, index_we, entry_we, or done pulse.

Verification
REQ-019 TLBWI:
- Stimulus: index_i=5, entryhi_i=32'h0040_2000, entrylo0_i=32'h0000_0046, entrylo1_i=32'h0000_0086.
- Response: one cycle later tlb_we=1, tlb_index=5, tlb_data={19'h00201,20'h2,1,1,20'h1,1,1}, done=1.
REQ-020 TLBR:
- Stimulus: index_i=5, tlb_rd_data as in REQ-019.
- Response: done and entry_we 2 cycles after acceptance; entryhi_o=32'h0040_2000, entrylo0_o=32'h0000_0046, entrylo1_o=32'h0000_0086.
REQ-021 TLBP hit: VPN2 stored at entries 9 and 12 -> index_o=9, index_we=1, done 11 cycles after acceptance.
REQ-022 TLBP miss -> index_o=32'h8000_0000, done 17 cycles after acceptance; op_valid pulses during the scan are ignored.
REQ-023 Random:
- wired_i=3 after reset -> random_o sequence 15,14,...,3,15.
- TLBWR accepted when random_o=7 writes index 7.
REQ-024 Reset mid-TLBP (cycle 4): rst=0 -> busy=0, no index_we or done pulse, random_o=15.
